// File: rtl/serial_cmp_pkg.sv
// serial_cmp_pkg: FSM state, compare result type and parallel compare helper for the MSB-first pair transmitter
package serial_cmp_pkg;
  typedef enum logic [1:0] {IDLE, FRAME, SHIFT} state_t;
  typedef struct packed {
    logic less;
    logic eq;
    logic greater;
  } cmp_res_t;
  localparam int CNT_W = 5;
  function automatic cmp_res_t cmp_pair(input logic [31:0] a, input logic [31:0] b);
    cmp_pair = '{less: a < b, eq: a == b, greater: a > b};
  endfunction
endpackage

// File: rtl/serial_pair_tx_msb_first_if.sv
// serial_pair_tx_msb_first_if: parallel pair handshake in, serial MSB-first pair out
interface serial_pair_tx_msb_first_if #(parameter int W = 8);
  logic         up_valid;
  logic         up_ready;
  logic [W-1:0] up_a;
  logic [W-1:0] up_b;
  logic         down_rst;
  logic         down_valid;
  logic         a;
  logic         b;
  logic         down_last;
  modport master (
    input  up_valid, up_a, up_b,
    output up_ready, down_rst, down_valid, a, b, down_last
  );
  modport slave (
    output up_valid, up_a, up_b,
    input  up_ready, down_rst, down_valid, a, b, down_last
  );
endinterface

// File: rtl/serial_pair_shift_reg.sv
// serial_pair_shift_reg: paired W-bit left shift registers with zero fill, load has priority over shift
module serial_pair_shift_reg #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d_a,
  input  logic [W-1:0] d_b,
  output logic         msb_a,
  output logic         msb_b
);
  logic [W-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d;
  always_comb begin
    sh_a_d = load ? d_a : shift ? sh_a_q << 1 : sh_a_q;
    sh_b_d = load ? d_b : shift ? sh_b_q << 1 : sh_b_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_a_q <= '0;
      sh_b_q <= '0;
    end else begin
      sh_a_q <= sh_a_d;
      sh_b_q <= sh_b_d;
    end
  end
  assign msb_a = sh_a_q[W-1];
  assign msb_b = sh_b_q[W-1];
endmodule

// File: rtl/serial_pair_tx_msb_first.sv
// serial_pair_tx_msb_first: serialises operand pairs MSB first behind a one-cycle down_rst frame pulse
// Optional SERIAL_PAIR_TX_REF_EN adds exp_less/exp_eq/exp_greater, valid on the last bit of each frame.
module serial_pair_tx_msb_first
  import serial_cmp_pkg::*;
#(parameter int W = 8) (
  input logic clk,
  input logic rst,
`ifdef SERIAL_PAIR_TX_REF_EN
  output logic exp_less,
  output logic exp_eq,
  output logic exp_greater,
`endif
  serial_pair_tx_msb_first_if.master bus
);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hs, last, msb_a, msb_b;
  assign last = state_q == SHIFT && cnt_q == '0;
  assign hs   = bus.up_valid & bus.up_ready;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q == FRAME ? SHIFT
            : (state_q == IDLE || last) ? (hs ? FRAME : IDLE)
            : state_q == SHIFT ? SHIFT : IDLE;
    cnt_d   = state_q == FRAME ? CNT_W'(W - 1)
            : (state_q == SHIFT && !last) ? cnt_q - CNT_W'(1) : cnt_q;
  end
  // up_ready depends on registers only, so nothing on up_* reaches the down side combinationally
  always_comb begin
    bus.up_ready   = state_q == IDLE || last;
    bus.down_rst   = state_q == FRAME;
    bus.down_valid = state_q == SHIFT;
    bus.a          = state_q == SHIFT && msb_a;
    bus.b          = state_q == SHIFT && msb_b;
    bus.down_last  = last;
  end
  serial_pair_shift_reg #(.W(W)) u_sh (
    .clk  (clk),
    .rst  (rst),
    .load (hs),
    .shift(state_q == SHIFT),
    .d_a  (bus.up_a),
    .d_b  (bus.up_b),
    .msb_a(msb_a),
    .msb_b(msb_b)
  );
`ifdef SERIAL_PAIR_TX_REF_EN
  cmp_res_t cmp_q, cmp_d;
  always_comb cmp_d = hs ? cmp_pair(32'(bus.up_a), 32'(bus.up_b)) : cmp_q;
  always_ff @(posedge clk) begin
    if (!rst) cmp_q <= '0;
    else cmp_q <= cmp_d;
  end
  always_comb begin
    exp_less    = last && cmp_q.less;
    exp_eq      = last && cmp_q.eq;
    exp_greater = last && cmp_q.greater;
  end
`endif
endmodule

// File: tb/tb_serial_pair_tx_msb_first.sv
// tb_serial_pair_tx_msb_first: random and directed pairs, scoreboard monitor with a serial comparator model
module tb_serial_pair_tx_msb_first;
  localparam int W = 8;
  logic clk = 0;
  logic rst = 0;
  always #5 clk = ~clk;
  serial_pair_tx_msb_first_if #(.W(W)) bus ();
  serial_pair_tx_msb_first_if #(.W(1)) bus1 ();
`ifdef SERIAL_PAIR_TX_REF_EN
  logic exp_less, exp_eq, exp_greater, e1_less, e1_eq, e1_greater;
`endif
  serial_pair_tx_msb_first #(.W(W)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SERIAL_PAIR_TX_REF_EN
    .exp_less(exp_less),
    .exp_eq(exp_eq),
    .exp_greater(exp_greater),
`endif
    .bus(bus)
  );
  serial_pair_tx_msb_first #(.W(1)) dut1 (
    .clk(clk),
    .rst(rst),
`ifdef SERIAL_PAIR_TX_REF_EN
    .exp_less(e1_less),
    .exp_eq(e1_eq),
    .exp_greater(e1_greater),
`endif
    .bus(bus1)
  );
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           k;
  } pair_t;
  pair_t q[$];
  int tests = 0, fails = 0, cyc = 0, busy_until = -1;
  bit mon_en = 0, accepted = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // verdict encoding: 0 equal, 1 A<B, 2 A>B
  function automatic int ref_verdict(input logic [W-1:0] a, input logic [W-1:0] b);
    return a < b ? 1 : a > b ? 2 : 0;
  endfunction
  task automatic step();
    bit rst_low;
    int k;
    @(negedge clk);
    accepted = 0;
    rst_low  = !rst;
    k        = cyc;
    chk("up_ready", bus.up_ready, cyc > busy_until);
    if (!rst_low && bus.up_valid && bus.up_ready) begin
      q.push_back('{a: bus.up_a, b: bus.up_b, k: cyc});
      busy_until = cyc + W;
      accepted   = 1;
    end
    @(posedge clk);
    #1;
    if (rst_low) begin
      q.delete();
      busy_until = k;
    end
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.up_valid = 1;
    bus.up_a     = a;
    bus.up_b     = b;
    for (int i = 0; i < 64; i++) begin
      step();
      if (accepted) break;
    end
    chk("send_accepted", accepted, 1);
    bus.up_valid = 0;
  endtask
  bit           in_frame = 0, quiet = 0, slot_ok;
  int           nbits = 0, verdict = 0;
  logic [W-1:0] acc_a = '0, acc_b = '0;
  pair_t        p;
  always @(negedge clk) begin
    if (mon_en) begin
      if (quiet) begin
        chk("reset_quiet", {bus.down_rst, bus.down_valid, bus.a, bus.b, bus.down_last, bus.up_ready}, 6'b000001);
        quiet = 0;
      end
      chk("idle_zero", !bus.down_valid && (bus.a || bus.b || bus.down_last), 0);
      chk("rst_vs_valid", bus.down_rst && bus.down_valid, 0);
      if (bus.down_rst) begin
        slot_ok = 0;
        if (q.size() > 0) slot_ok = !in_frame && cyc == q[0].k + 1;
        chk("frame_start_slot", slot_ok, 1);
        in_frame = 1;
        nbits    = 0;
        verdict  = 0;
      end
      if (bus.down_valid) begin
        chk("bit_in_frame", in_frame, 1);
        acc_a = {acc_a[W-2:0], bus.a};
        acc_b = {acc_b[W-2:0], bus.b};
        nbits++;
        if (verdict == 0 && bus.a != bus.b) verdict = bus.a ? 2 : 1;
        if (bus.down_last) begin
          chk("frame_len", nbits, W);
          chk("pending_pair", q.size() > 0, 1);
          if (q.size() > 0) begin
            p = q.pop_front();
            chk("serial_a", acc_a, p.a);
            chk("serial_b", acc_b, p.b);
            chk("last_latency", cyc, p.k + 1 + W);
            chk("serial_verdict", verdict, ref_verdict(p.a, p.b));
`ifdef SERIAL_PAIR_TX_REF_EN
            chk("exp_onehot", {exp_less, exp_eq, exp_greater},
                ref_verdict(p.a, p.b) == 1 ? 3'b100 : ref_verdict(p.a, p.b) == 0 ? 3'b010 : 3'b001);
`endif
          end
          in_frame = 0;
        end else chk("last_in_time", nbits < W, 1);
      end
`ifdef SERIAL_PAIR_TX_REF_EN
      if (!bus.down_last) chk("exp_idle", {exp_less, exp_eq, exp_greater}, 0);
`endif
      if (!rst) begin
        in_frame = 0;
        quiet    = 1;
      end
    end
  end
  initial begin
    logic [W-1:0] ra, rb;
    bus.up_valid  = 0;
    bus.up_a      = '0;
    bus.up_b      = '0;
    bus1.up_valid = 0;
    bus1.up_a     = '0;
    bus1.up_b     = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {bus.up_ready, bus.down_rst, bus.down_valid, bus.down_last, bus.a, bus.b}, 6'b100000);
    chk("reset_state_w1", {bus1.up_ready, bus1.down_rst, bus1.down_valid, bus1.down_last, bus1.a, bus1.b}, 6'b100000);
    @(posedge clk);
    #1;
    rst    = 1;
    mon_en = 1;
    send(8'hA5, 8'hA4);
    repeat (12) step();
    send(8'h00, 8'hFF);
    send(8'h3C, 8'h3C);
    repeat (12) step();
    send(8'h5A, 8'h0F);
    repeat (3) step();
    bus.up_valid = 1;
    bus.up_a     = 8'hFF;
    bus.up_b     = 8'h00;
    step();
    bus.up_valid = 0;
    repeat (10) step();
    send(8'hC3, 8'h81);
    repeat (3) step();
    rst = 0;
    step();
    rst = 1;
    step();
    send(8'h7E, 8'h7F);
    repeat (12) step();
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = $urandom_range(0, 3) == 0 ? ra : W'($urandom);
      send(ra, rb);
      repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 12) : 0) step();
    end
    for (int i = 0; i < 40 && (q.size() > 0 || in_frame); i++) step();
    chk("drained", q.size(), 0);
    bus1.up_valid = 1;
    bus1.up_a     = 1'b1;
    bus1.up_b     = 1'b0;
    @(negedge clk);
    chk("w1_ready_idle", bus1.up_ready, 1);
    @(posedge clk);
    #1;
    bus1.up_a = 1'b0;
    bus1.up_b = 1'b1;
    @(negedge clk);
    chk("w1_frame", {bus1.down_rst, bus1.down_valid, bus1.down_last, bus1.up_ready}, 4'b1000);
    @(negedge clk);
    chk("w1_bit_a1_b0", {bus1.down_rst, bus1.down_valid, bus1.a, bus1.b, bus1.down_last, bus1.up_ready}, 6'b011011);
`ifdef SERIAL_PAIR_TX_REF_EN
    chk("w1_exp_greater", {e1_less, e1_eq, e1_greater}, 3'b001);
`endif
    @(posedge clk);
    #1;
    bus1.up_valid = 0;
    @(negedge clk);
    chk("w1_frame2", {bus1.down_rst, bus1.down_valid, bus1.down_last, bus1.up_ready}, 4'b1000);
    @(negedge clk);
    chk("w1_bit_a0_b1", {bus1.down_rst, bus1.down_valid, bus1.a, bus1.b, bus1.down_last, bus1.up_ready}, 6'b010111);
`ifdef SERIAL_PAIR_TX_REF_EN
    chk("w1_exp_less", {e1_less, e1_eq, e1_greater}, 3'b100);
`endif
    @(negedge clk);
    chk("w1_idle", {bus1.down_rst, bus1.down_valid, bus1.a, bus1.b, bus1.down_last, bus1.up_ready}, 6'b000001);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_pair_tx_msb_first.md
SERIAL_PAIR_TX_MSB_FIRST -- requirements
Module: serial_pair_tx_msb_first

Interface
REQ-001 Parameter W, default 8: operand width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
REQ-004 up_valid  input  1  parallel operand pair valid.
REQ-005 up_ready  output  1  block accepts a pair this cycle.
REQ-006 up_a  input  W  operand A, parallel.
REQ-007 up_b  input  W  operand B, parallel.
REQ-008 down_rst  output  1  active-high one-cycle frame-start pulse that clears a downstream serial comparator.
REQ-009 down_valid  output  1  a/b carry a valid bit this cycle.
REQ-010 a  output  1  serial bit of A, MSB first.
REQ-011 b  output  1  serial bit of B, MSB first.
REQ-012 down_last  output  1  current bit is the LSB (final bit of the frame).

Function
REQ-013 FSM states SHALL be IDLE, FRAME, SHIFT.
REQ-014 Handshake SHALL occur when up_valid & up_ready are both 1 on a rising edge; up_a/up_b SHALL be captured into shift registers sh_a/sh_b on that edge.
REQ-015 up_ready SHALL be 1 in IDLE, 1 in SHIFT when down_last is 1, and 0 otherwise.
REQ-016 IDLE: on handshake go to FRAME; else stay in IDLE.
REQ-017 FRAME: down_rst=1, down_valid=0; bit counter loads W-1; next state is always SHIFT.
REQ-018 SHIFT: down_valid=1, a=sh_a[W-1], b=sh_b[W-1]; sh_a/sh_b shift left by one per cycle with zero fill; counter decrements.
REQ-019 down_last SHALL be 1 in SHIFT when counter==0; on that cycle, handshake goes to FRAME, otherwise to IDLE.
REQ-020 Latency: handshake at edge N gives down_rst high in cycle N+1, MSB in cycle N+2, LSB with down_last in cycle N+1+W.
REQ-021 Back-to-back throughput SHALL be one pair per W+1 cycles with no idle gap between frames.
REQ-022 Outside SHIFT, a, b, down_valid and down_last SHALL be 0; outside FRAME, down_rst SHALL be 0.
REQ-023 W=1: the frame SHALL be FRAME followed by one SHIFT cycle with down_last=1.
REQ-024 up_valid while up_ready=0 SHALL be ignored; the held pair is accepted later, when up_ready is 1.
REQ-025 All outputs SHALL be driven from registers or decoded only from the state register, with no combinational path from up_* to down side.

Reset
REQ-026 With rst=0 at a rising edge: state=IDLE, counter=0, sh_a=sh_b=0.
REQ-027 Outputs during and after reset: up_ready=1; down_rst, down_valid, down_last, a, b all 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with no further down_valid until a new handshake.

Configuration
REQ-029 Macro SERIAL_PAIR_TX_REF_EN: when defined, outputs exp_less, exp_eq, exp_greater (1 bit each) SHALL be added.
REQ-030 With SERIAL_PAIR_TX_REF_EN: the parallel compare of up_a vs up_b (unsigned) is registered at handshake; the result is valid only when down_last=1 and is 0 otherwise; it is exactly one-hot.
REQ-031 Without SERIAL_PAIR_TX_REF_EN: these ports and their logic SHALL be absent; behaviour is otherwise identical.

Structure
REQ-032 Package serial_cmp_pkg SHALL hold the FSM state enum (IDLE, FRAME, SHIFT) and the cmp_res_t typedef (less/eq/greater struct).
REQ-033 Sub-module serial_pair_shift_reg (parameter W; load, shift, msb outputs) SHALL implement sh_a/sh_b; the FSM and counter live in the top.

Verification
REQ-034 W=8, pair A=0xA5, B=0xA4 -> down_rst pulse, then a=1,0,1,0,0,1,0,1, b=1,0,1,0,0,1,0,0; down_last on the 8th bit; with REF_EN, exp_greater=1.
REQ-035 Two pairs held valid, (0x00,0xFF) then (0x3C,0x3C) -> frames separated by exactly one down_rst cycle; second-frame a==b every bit; with REF_EN, exp_less then exp_eq.
REQ-036 up_valid pulsed during SHIFT before down_last -> ignored; no extra frame is emitted.
REQ-037 rst=0 asserted at the 3rd SHIFT bit -> next cycle all down outputs 0, up_ready=1; the next handshake gives a clean full frame.
REQ-038 W=1, pair (1,0) -> FRAME then one SHIFT cycle with a=1, b=0, down_last=1; the next pair is accepted on that cycle.
REQ-039 Feed the outputs into a downstream MSB-first serial comparator (down_rst to its rst) over 1000 random pairs -> its final-bit verdict matches the parallel compare every frame.
